// File: rtl/mips_multicycle.sv
// Multicycle MIPS subset core on a single word-addressed memory bus.
// A transfer completes on a rising edge where mem_req and mem_ready are both high.
module mips_multicycle #(
    parameter int XLEN = 32,
    parameter int AW = 16,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            mem_req,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ready,
    output logic [AW-1:0]   pc,
    output logic            halted
);
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

    localparam logic [5:0] OP_R = 6'h00, OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [5:0] OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_J = 6'h02, OP_JAL = 6'h03;
    localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25, F_SLT = 6'h2A;

    state_t          state, state_n;
    logic [31:0]     ir;
    logic [XLEN-1:0] regs [32];
    logic [XLEN-1:0] a, b, imm, alu_out, mdr, alu_res, wb_data;
    logic [5:0]      op, funct;
    logic [4:0]      wb_addr;
    logic            wb_en, legal, taken, handshake;

    assign op        = ir[31:26];
    assign funct     = ir[5:0];
    assign handshake = mem_req & mem_ready;
    assign halted    = (state == HALT);
    assign taken     = ((op == OP_BEQ) && (a == b)) || ((op == OP_BNE) && (a != b));

    logic unused_bits;
    assign unused_bits = ^ir[10:6];
    if (XLEN > 32) begin : g_wide
        logic unused_rdata;
        assign unused_rdata = ^mem_rdata[XLEN-1:32];
    end

    always_comb begin
        legal = 1'b0;
        case (op)
            OP_R:    legal = funct inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT};
            OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL: legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    // Non-R opcodes reaching the ALU are addi/lw/sw, all of which need A+imm.
    always_comb begin
        alu_res = a + imm;
        if (op == OP_R) begin
            case (funct)
                F_ADD:   alu_res = a + b;
                F_SUB:   alu_res = a - b;
                F_AND:   alu_res = a & b;
                F_OR:    alu_res = a | b;
                F_SLT:   alu_res = XLEN'($signed(a) < $signed(b));
                default: alu_res = a + b;
            endcase
        end
    end

    // jal links in EXEC, where pc already points past the jal itself.
    always_comb begin
        wb_en   = 1'b0;
        wb_addr = ir[20:16];
        wb_data = alu_out;
        if (state == WB) begin
            wb_en = 1'b1;
            if (op == OP_R) wb_addr = ir[15:11];
            else if (op == OP_LW) wb_data = mdr;
        end else if ((state == EXEC) && (op == OP_JAL)) begin
            wb_en   = 1'b1;
            wb_addr = 5'd31;
            wb_data = XLEN'(pc);
        end
    end

    always_comb begin
        state_n   = state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = pc;
        mem_wdata = b;
        case (state)
            FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) state_n = DECODE;
            end
            DECODE: state_n = legal ? EXEC : HALT;
            EXEC: begin
                case (op)
                    OP_BEQ, OP_BNE, OP_J, OP_JAL: state_n = FETCH;
                    OP_LW, OP_SW:                 state_n = MEM;
                    default:                      state_n = WB;
                endcase
            end
            MEM: begin
                mem_req  = 1'b1;
                mem_we   = (op == OP_SW);
                mem_addr = AW'(alu_out);
                if (mem_ready) state_n = (op == OP_SW) ? FETCH : WB;
            end
            WB:      state_n = FETCH;
            HALT:    state_n = HALT;
            default: state_n = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= FETCH;
            pc      <= RESET_PC;
            ir      <= '0;
            a       <= '0;
            b       <= '0;
            imm     <= '0;
            alu_out <= '0;
            mdr     <= '0;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else begin
            state <= state_n;
            case (state)
                FETCH: begin
                    if (handshake) begin
                        ir <= mem_rdata[31:0];
                        pc <= pc + AW'(1);
                    end
                end
                DECODE: begin
                    a   <= regs[ir[25:21]];
                    b   <= regs[ir[20:16]];
                    imm <= {{(XLEN-16){ir[15]}}, ir[15:0]};
                end
                EXEC: begin
                    alu_out <= alu_res;
                    if (taken) pc <= pc + AW'(imm);
                    else if ((op == OP_J) || (op == OP_JAL)) pc <= AW'(ir[25:0]);
                end
                MEM: begin
                    if (handshake && (op == OP_LW)) mdr <= mem_rdata;
                end
                default: ;
            endcase
            if (wb_en && (wb_addr != 5'd0)) regs[wb_addr] <= wb_data;
        end
    end
endmodule

// File: tb/tb_mips_multicycle.sv
// Bench for mips_multicycle: programs run from a bench-side memory; stores are
// checked against an expected queue, timing via pc/bus samples on the falling edge.
module tb_mips_multicycle;
    localparam int XLEN = 32;
    localparam int AW = 16;
    localparam logic [5:0] OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [5:0] OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_J = 6'h02, OP_JAL = 6'h03;
    localparam logic [31:0] HALT_INS = 32'hFC00_0000;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            rst_w_n = 1'b1;
    logic            mem_req, mem_we, mem_ready, halted;
    logic [AW-1:0]   mem_addr, pc;
    logic [XLEN-1:0] mem_wdata, mem_rdata;
    logic [31:0]     mem [1024];

    logic            w_req, w_we, w_halted;
    logic [9:0]      w_addr, w_pc;
    logic [63:0]     w_wdata, w_rdata;
    logic [31:0]     mem_w [1024];

    int checks = 0;
    int errors = 0;
    logic [AW+XLEN-1:0] exp_q[$];
    logic [10+64-1:0]   exp_w_q[$];

    assign mem_rdata = mem[mem_addr[9:0]];
    assign w_rdata   = {32'h0, mem_w[w_addr]};

    mips_multicycle u_dut (
        .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .pc(pc), .halted(halted)
    );

    mips_multicycle #(.XLEN(64), .AW(10)) u_wide (
        .clk(clk), .rst_n(rst_w_n), .mem_req(w_req), .mem_we(w_we),
        .mem_addr(w_addr), .mem_wdata(w_wdata), .mem_rdata(w_rdata),
        .mem_ready(1'b1), .pc(w_pc), .halted(w_halted)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1 rst_w_n = 1'b0;
    end

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached, required completion earlier");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboards ----------------
    always @(posedge clk) begin : mon_narrow
        logic [AW+XLEN-1:0] exp_v;
        if (rst_n && mem_req && mem_we && mem_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr=%0h data=%0h, required no write", mem_addr, mem_wdata);
            end else begin
                exp_v = exp_q.pop_front();
                if ({mem_addr, mem_wdata} !== exp_v)
                begin
                    errors++;
                    $display("FAIL store: addr=%0h data=%0h, required addr=%0h data=%0h",
                             mem_addr, mem_wdata, exp_v[AW+XLEN-1:XLEN], exp_v[XLEN-1:0]);
                end
            end
            mem[mem_addr[9:0]] <= mem_wdata;
        end
    end

    always @(posedge clk) begin : mon_wide
        logic [73:0] exp_v;
        if (rst_w_n && w_req && w_we) begin
            checks++;
            if (exp_w_q.size() == 0) begin
                errors++;
                $display("FAIL wide_unexpected_write: addr=%0h data=%0h, required no write", w_addr, w_wdata);
            end else begin
                exp_v = exp_w_q.pop_front();
                if ({w_addr, w_wdata} !== exp_v) begin
                    errors++;
                    $display("FAIL wide_store: addr=%0h data=%0h, required addr=%0h data=%0h",
                             w_addr, w_wdata, exp_v[73:64], exp_v[63:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] j_ins(input logic [5:0] op, input logic [25:0] t);
        return {op, t};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic begin_reset();
        @(negedge clk);
        rst_n = 1'b0;
        mem_ready = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 1024; i++) mem[i] = HALT_INS;
    endtask

    task automatic release_reset(input logic ready_val);
        @(negedge clk);
        mem_ready = ready_val;
        rst_n = 1'b1;
    endtask

    task automatic run_until_halt(input int bound, output bit ok);
        int n;
        n = 0;
        while (!halted && n < bound) begin
            step(1);
            n++;
        end
        ok = halted;
    endtask

    task automatic wait_writes(input int bound, output bit ok);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            step(1);
            n++;
        end
        ok = (exp_q.size() == 0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        begin_reset();
        #1;
        checks++;
        if (pc !== 16'd0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: pc=%0d halted=%0b, required pc=0 halted=0", pc, halted);
        end
        checks++;
        if (w_pc !== 10'd0 || w_halted !== 1'b0) begin
            errors++;
            $display("FAIL wide_reset_state: pc=%0d halted=%0b, required pc=0 halted=0", w_pc, w_halted);
        end
        release_reset(1'b1);
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'd0) begin
            errors++;
            $display("FAIL reset_fetch: req=%0b we=%0b addr=%0h, required req=1 we=0 addr=0",
                     mem_req, mem_we, mem_addr);
        end
    endtask

    task automatic test_arith();
        bit ok;
        logic [31:0] res [6];
        res = '{32'd2, 32'd8, 32'd5, 32'hFFFF_FFFD, 32'd1, 32'd0};
        begin_reset();
        mem[0] = i_ins(OP_ADDI, 5'd0, 5'd1, 16'd5);
        mem[1] = i_ins(OP_ADDI, 5'd0, 5'd2, 16'hFFFD);
        mem[2] = r_ins(5'd1, 5'd2, 5'd3, 6'h20);
        mem[3] = r_ins(5'd1, 5'd2, 5'd4, 6'h22);
        mem[4] = r_ins(5'd1, 5'd2, 5'd5, 6'h24);
        mem[5] = r_ins(5'd1, 5'd2, 5'd6, 6'h25);
        mem[6] = r_ins(5'd2, 5'd1, 5'd7, 6'h2A);
        mem[7] = r_ins(5'd1, 5'd2, 5'd8, 6'h2A);
        for (int k = 0; k < 6; k++) begin
            mem[8+k] = i_ins(OP_SW, 5'd0, 5'(3 + k), 16'(100 + k));
            exp_q.push_back({16'(100 + k), res[k]});
        end
        release_reset(1'b1);
        step(11);
        checks++;
        if (mem_req !== 1'b0) begin
            errors++;
            $display("FAIL arith_wb_idle: req=%0b at cycle 11, required 0", mem_req);
        end
        step(1);
        checks++;
        if (pc !== 16'd3 || mem_req !== 1'b1 || mem_addr !== 16'd3) begin
            errors++;
            $display("FAIL arith_12cyc: pc=%0d req=%0b addr=%0h, required pc=3 req=1 addr=3",
                     pc, mem_req, mem_addr);
        end
        run_until_halt(300, ok);
        checks++;
        if (!ok || exp_q.size() != 0) begin
            errors++;
            $display("FAIL arith_done: halted=%0b pending=%0d, required halted=1 pending=0", halted, exp_q.size());
        end
    endtask

    task automatic test_random_alu();
        bit ok;
        logic [15:0] x, y;
        logic [31:0] sx, sy;
        begin_reset();
        for (int r = 0; r < 4; r++) begin
            x = 16'($urandom_range(0, 65535));
            y = 16'($urandom_range(0, 65535));
            sx = {{16{x[15]}}, x};
            sy = {{16{y[15]}}, y};
            mem[r*8+0] = i_ins(OP_ADDI, 5'd0, 5'd1, x);
            mem[r*8+1] = i_ins(OP_ADDI, 5'd0, 5'd2, y);
            mem[r*8+2] = r_ins(5'd1, 5'd2, 5'd3, 6'h20);
            mem[r*8+3] = r_ins(5'd1, 5'd2, 5'd4, 6'h22);
            mem[r*8+4] = r_ins(5'd1, 5'd2, 5'd5, 6'h2A);
            mem[r*8+5] = i_ins(OP_SW, 5'd0, 5'd3, 16'(200 + r*3));
            mem[r*8+6] = i_ins(OP_SW, 5'd0, 5'd4, 16'(201 + r*3));
            mem[r*8+7] = i_ins(OP_SW, 5'd0, 5'd5, 16'(202 + r*3));
            exp_q.push_back({16'(200 + r*3), sx + sy});
            exp_q.push_back({16'(201 + r*3), sx - sy});
            exp_q.push_back({16'(202 + r*3), ($signed(sx) < $signed(sy)) ? 32'd1 : 32'd0});
        end
        release_reset(1'b1);
        run_until_halt(400, ok);
        checks++;
        if (!ok || exp_q.size() != 0) begin
            errors++;
            $display("FAIL random_alu_done: halted=%0b pending=%0d, required halted=1 pending=0", halted, exp_q.size());
        end
    endtask

    task automatic test_mem();
        bit ok;
        begin_reset();
        mem[0] = i_ins(OP_ADDI, 5'd0, 5'd1, 16'h1234);
        mem[1] = i_ins(OP_SW, 5'd0, 5'd1, 16'd0);
        mem[2] = i_ins(OP_LW, 5'd0, 5'd4, 16'd0);
        mem[3] = i_ins(OP_SW, 5'd0, 5'd4, 16'd50);
        exp_q.push_back({16'd0, 32'h1234});
        exp_q.push_back({16'd50, 32'h1234});
        release_reset(1'b1);
        step(11);
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'd0 || pc !== 16'd3) begin
            errors++;
            $display("FAIL lw_read: req=%0b we=%0b addr=%0h pc=%0d, required req=1 we=0 addr=0 pc=3",
                     mem_req, mem_we, mem_addr, pc);
        end
        step(2);
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 16'd3 || pc !== 16'd3) begin
            errors++;
            $display("FAIL lw_5cyc: req=%0b addr=%0h pc=%0d, required req=1 addr=3 pc=3", mem_req, mem_addr, pc);
        end
        run_until_halt(100, ok);
        checks++;
        if (!ok || exp_q.size() != 0) begin
            errors++;
            $display("FAIL mem_done: halted=%0b pending=%0d, required halted=1 pending=0", halted, exp_q.size());
        end
    endtask

    task automatic test_stall();
        bit ok;
        begin_reset();
        mem[0] = i_ins(OP_ADDI, 5'd0, 5'd1, 16'd7);
        mem[1] = i_ins(OP_SW, 5'd0, 5'd1, 16'd60);
        exp_q.push_back({16'd60, 32'd7});
        release_reset(1'b0);
        for (int c = 0; c < 3; c++) begin
            step(1);
            checks++;
            if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'd0 || pc !== 16'd0) begin
                errors++;
                $display("FAIL stall_hold%0d: req=%0b we=%0b addr=%0h pc=%0d, required req=1 we=0 addr=0 pc=0",
                         c, mem_req, mem_we, mem_addr, pc);
            end
        end
        mem_ready = 1'b1;
        step(1);
        checks++;
        if (pc !== 16'd1) begin
            errors++;
            $display("FAIL stall_accept: pc=%0d, required 1", pc);
        end
        step(3);
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 16'd1) begin
            errors++;
            $display("FAIL stall_latency: req=%0b addr=%0h at cycle 7, required req=1 addr=1", mem_req, mem_addr);
        end
        run_until_halt(100, ok);
        checks++;
        if (!ok || exp_q.size() != 0) begin
            errors++;
            $display("FAIL stall_done: halted=%0b pending=%0d, required halted=1 pending=0", halted, exp_q.size());
        end
    endtask

    task automatic test_branch();
        bit ok;
        begin_reset();
        mem[0] = j_ins(OP_J, 26'd7);
        mem[7] = i_ins(OP_BEQ, 5'd0, 5'd0, 16'hFFFF);
        release_reset(1'b1);
        step(3);
        checks++;
        if (pc !== 16'd7) begin
            errors++;
            $display("FAIL j_target: pc=%0d, required 7", pc);
        end
        for (int it = 0; it < 3; it++) begin
            step(1);
            checks++;
            if (pc !== 16'd8) begin
                errors++;
                $display("FAIL beq_fetch%0d: pc=%0d, required 8", it, pc);
            end
            step(2);
            checks++;
            if (pc !== 16'd7) begin
                errors++;
                $display("FAIL beq_loop%0d: pc=%0d, required 7", it, pc);
            end
        end

        begin_reset();
        mem[0] = j_ins(OP_J, 26'd7);
        mem[7] = i_ins(OP_BNE, 5'd0, 5'd0, 16'hFFFF);
        release_reset(1'b1);
        step(6);
        checks++;
        if (pc !== 16'd8 || halted !== 1'b0) begin
            errors++;
            $display("FAIL bne_fallthru: pc=%0d halted=%0b, required pc=8 halted=0", pc, halted);
        end
        step(2);
        checks++;
        if (pc !== 16'd9 || halted !== 1'b1) begin
            errors++;
            $display("FAIL bne_halt: pc=%0d halted=%0b, required pc=9 halted=1", pc, halted);
        end

        begin_reset();
        mem[0]  = j_ins(OP_J, 26'd4);
        mem[4]  = j_ins(OP_JAL, 26'd20);
        mem[20] = i_ins(OP_ADDI, 5'd0, 5'd0, 16'd9);
        mem[21] = i_ins(OP_SW, 5'd0, 5'd31, 16'd70);
        mem[22] = i_ins(OP_SW, 5'd0, 5'd0, 16'd71);
        mem[23] = i_ins(OP_BEQ, 5'd31, 5'd0, 16'd1);
        mem[24] = i_ins(OP_BNE, 5'd31, 5'd0, 16'd1);
        mem[25] = i_ins(OP_SW, 5'd0, 5'd0, 16'd72);
        exp_q.push_back({16'd70, 32'd5});
        exp_q.push_back({16'd71, 32'd0});
        release_reset(1'b1);
        step(6);
        checks++;
        if (pc !== 16'd20) begin
            errors++;
            $display("FAIL jal_target: pc=%0d, required 20", pc);
        end
        run_until_halt(100, ok);
        checks++;
        if (!ok || exp_q.size() != 0 || pc !== 16'd27) begin
            errors++;
            $display("FAIL jal_done: halted=%0b pending=%0d pc=%0d, required halted=1 pending=0 pc=27",
                     halted, exp_q.size(), pc);
        end
    endtask

    task automatic test_halt();
        logic [31:0] bad [3];
        bad = '{HALT_INS, r_ins(5'd1, 5'd2, 5'd3, 6'h21), 32'h3C01_0005};
        for (int k = 0; k < 3; k++) begin
            begin_reset();
            mem[0] = bad[k];
            release_reset(1'b1);
            step(1);
            checks++;
            if (halted !== 1'b0) begin
                errors++;
                $display("FAIL halt_early%0d: halted=%0b, required 0", k, halted);
            end
            step(1);
            checks++;
            if (halted !== 1'b1 || mem_req !== 1'b0 || pc !== 16'd1) begin
                errors++;
                $display("FAIL halt_enter%0d: halted=%0b req=%0b pc=%0d, required halted=1 req=0 pc=1",
                         k, halted, mem_req, pc);
            end
            step(4);
            checks++;
            if (halted !== 1'b1 || mem_req !== 1'b0 || pc !== 16'd1) begin
                errors++;
                $display("FAIL halt_stay%0d: halted=%0b req=%0b pc=%0d, required halted=1 req=0 pc=1",
                         k, halted, mem_req, pc);
            end
        end
    endtask

    task automatic test_reset_mid_fetch();
        bit ok;
        begin_reset();
        mem[0] = i_ins(OP_SW, 5'd0, 5'd1, 16'd90);
        mem[1] = i_ins(OP_ADDI, 5'd0, 5'd1, 16'd3);
        mem[2] = j_ins(OP_J, 26'd0);
        exp_q.push_back({16'd90, 32'd0});
        exp_q.push_back({16'd90, 32'd3});
        exp_q.push_back({16'd90, 32'd0});
        release_reset(1'b1);
        step(15);
        mem_ready = 1'b0;
        step(2);
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 16'd1 || pc !== 16'd1 || exp_q.size() != 1) begin
            errors++;
            $display("FAIL pre_reset: req=%0b addr=%0h pc=%0d pending=%0d, required req=1 addr=1 pc=1 pending=1",
                     mem_req, mem_addr, pc, exp_q.size());
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (pc !== 16'd0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: pc=%0d halted=%0b, required pc=0 halted=0", pc, halted);
        end
        release_reset(1'b1);
        step(1);
        checks++;
        if (pc !== 16'd1) begin
            errors++;
            $display("FAIL refetch: pc=%0d, required 1", pc);
        end
        wait_writes(20, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL reset_regs_cleared: pending=%0d, required 0", exp_q.size());
        end
    endtask

    task automatic test_wide();
        int n;
        begin_reset();
        for (int i = 0; i < 1024; i++) mem_w[i] = i_ins(OP_ADDI, 5'd0, 5'd0, 16'd0);
        mem_w[0] = i_ins(OP_ADDI, 5'd0, 5'd1, 16'hFFFF);
        mem_w[1] = i_ins(OP_SW, 5'd0, 5'd1, 16'd5);
        mem_w[2] = i_ins(OP_ADDI, 5'd0, 5'd0, 16'd9);
        mem_w[3] = i_ins(OP_SW, 5'd0, 5'd0, 16'd6);
        exp_w_q.push_back({10'd5, 64'hFFFF_FFFF_FFFF_FFFF});
        exp_w_q.push_back({10'd6, 64'd0});
        @(negedge clk);
        rst_w_n = 1'b1;
        n = 0;
        while (w_pc != 10'd1023 && n < 6000) begin
            step(1);
            n++;
        end
        checks++;
        if (w_pc !== 10'd1023) begin
            errors++;
            $display("FAIL wide_reach_top: pc=%0d, required 1023", w_pc);
        end
        n = 0;
        while (w_pc == 10'd1023 && n < 10) begin
            step(1);
            n++;
        end
        checks++;
        if (w_pc !== 10'd0 || w_halted !== 1'b0) begin
            errors++;
            $display("FAIL wide_pc_wrap: pc=%0d halted=%0b, required pc=0 halted=0", w_pc, w_halted);
        end
        checks++;
        if (exp_w_q.size() != 0) begin
            errors++;
            $display("FAIL wide_writes: pending=%0d, required 0", exp_w_q.size());
        end
        rst_w_n = 1'b0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        mem_ready = 1'b1;
        test_reset();
        test_arith();
        test_random_alu();
        test_mem();
        test_stall();
        test_branch();
        test_halt();
        test_reset_mid_fetch();
        test_wide();
        begin_reset();
        step(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
